// File: rtl/dcache_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dcache_mem_responder_pkg
// Brief   : Shared cache/memory widths and responder FSM state encoding.
// Rev     : 1.0 - initial release
// ============================================================================
package dcache_mem_responder_pkg;

    localparam int c_ADDRBITS      = 32;
    localparam int c_DATABITS      = 32;
    localparam int c_CACHEWORDS    = 32;
    localparam int c_CACHEADDRBITS = $clog2(c_CACHEWORDS);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_BURST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_WAIT  = c_ST_WAIT,
        ST_BURST = c_ST_BURST
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_mem_responder_sram.sv
`default_nettype none
// ============================================================================
// Module  : mem_sram
// Brief   : Single-port synchronous RAM, one access per cycle, read data next
//           cycle. Write has priority over read when both are requested.
// Rev     : 1.0 - initial release
// ============================================================================
module mem_sram
    import dcache_mem_responder_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = c_DATABITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dcache_mem_responder
// Brief   : Memory-side responder for dcache line refill bursts and writebacks,
//           backed by a word-addressed single-port store.
// Rev     : 1.0 - initial release
// ============================================================================
module dcache_mem_responder
    import dcache_mem_responder_pkg::*;
#(
    parameter int ADDRBITS = c_ADDRBITS,
    parameter int DATABITS = c_DATABITS,
    parameter int MEMBITS  = 12,
    parameter int BURSTLEN = c_CACHEWORDS,
    parameter int RDLAT    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDRBITS-1:0] mem_addr,
    input  logic                mem_rdreq,
    input  logic                mem_wrreq,
    input  logic [DATABITS-1:0] mem_datain,
    input  logic                mem_stall,
    output logic [DATABITS-1:0] mem_out,
    output logic                mem_valid,
    output logic [15:0]         mem_burstlen,
    output logic                mem_busy,
    output logic                mem_rderr
);

    localparam int                c_CNTW     = $clog2(BURSTLEN + 1);
    localparam int                c_LATW     = $clog2(RDLAT + 1);
    localparam logic [c_CNTW-1:0] c_LAST     = c_CNTW'(BURSTLEN - 1);
    localparam logic [c_CNTW-1:0] c_CNT_ONE  = c_CNTW'(1);
    localparam logic [c_LATW-1:0] c_LAT_LOAD = c_LATW'(RDLAT - 1);
    localparam logic [c_LATW-1:0] c_LAT_ONE  = c_LATW'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MEMBITS-1:0]  r_start;
    logic [MEMBITS-1:0]  w_start_nxt;
    logic [c_CNTW-1:0]   r_cnt;
    logic [c_CNTW-1:0]   w_cnt_nxt;
    logic [c_LATW-1:0]   r_lat;
    logic [c_LATW-1:0]   w_lat_nxt;
    logic                r_valid;
    logic                r_last;
    logic                r_busy;
    logic                r_rderr;

    logic [MEMBITS-1:0]  w_widx;
    logic [MEMBITS-1:0]  w_rd_idx;
    logic [MEMBITS-1:0]  w_ram_addr;
    logic [c_CNTW-1:0]   w_cur_cnt;
    logic                w_accept;
    logic                w_slot;
    logic                w_issue;
    logic                w_is_last;
    logic                w_unused;

    assign w_widx   = mem_addr[MEMBITS+1:2];
    assign w_unused = ^{mem_addr[ADDRBITS-1:MEMBITS+2], mem_addr[1:0]};

    // Busy covers the trailing cycle in which the last word is still on
    // mem_out, so a new request is only accepted once busy has dropped.
    assign w_accept = mem_rdreq && !r_busy;

    // The RAM adds one cycle of read latency, so a word is fetched one cycle
    // before it must appear: the WAIT slot opens when the latency count hits 1,
    // or directly on acceptance when RDLAT is 1.
    always_comb begin
        w_slot = 1'b0;
        case (r_state)
            ST_IDLE:  w_slot = (RDLAT == 1) && w_accept;
            ST_WAIT:  w_slot = (r_lat <= c_LAT_ONE);
            ST_BURST: w_slot = 1'b1;
            default:  w_slot = 1'b0;
        endcase
    end

    // A write owns the single RAM port; stall and collision both cost one slot.
    assign w_issue    = w_slot && !mem_wrreq && !mem_stall;
    assign w_cur_cnt  = (r_state == ST_IDLE) ? '0 : r_cnt;
    assign w_is_last  = (w_cur_cnt == c_LAST);
    assign w_rd_idx   = (r_state == ST_IDLE) ? w_widx : (r_start + MEMBITS'(r_cnt));
    assign w_ram_addr = mem_wrreq ? w_widx : w_rd_idx;

    mem_sram #(
        .AW (MEMBITS),
        .DW (DATABITS)
    ) u_sram (
        .clk     (clk),
        .rst     (reset),
        .i_we    (mem_wrreq),
        .i_re    (w_issue),
        .i_addr  (w_ram_addr),
        .i_wdata (mem_datain),
        .o_rdata (mem_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = r_start;
        w_cnt_nxt   = r_cnt;
        w_lat_nxt   = r_lat;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_start_nxt = w_widx;
                    w_cnt_nxt   = '0;
                    w_lat_nxt   = c_LAT_LOAD;
                    w_state_nxt = ST_WAIT;
                    if (w_issue) begin
                        w_cnt_nxt   = c_CNT_ONE;
                        w_state_nxt = w_is_last ? ST_IDLE : ST_BURST;
                    end
                end
            end
            ST_WAIT: begin
                if (r_lat > c_LAT_ONE) begin
                    w_lat_nxt = r_lat - c_LAT_ONE;
                end else if (w_issue) begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    w_state_nxt = w_is_last ? ST_IDLE : ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_issue) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                    if (w_is_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start <= '0;
            r_cnt   <= '0;
            r_lat   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_rderr <= 1'b0;
        end else begin
            r_start <= w_start_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lat   <= w_lat_nxt;
            r_valid <= w_issue;
            r_last  <= w_issue && w_is_last;
            r_rderr <= mem_rdreq && r_busy;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_valid && r_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign mem_valid    = r_valid;
    assign mem_busy     = r_busy;
    assign mem_rderr    = r_rderr;
    assign mem_burstlen = 16'(BURSTLEN);

endmodule
`default_nettype wire

// File: doc/dcache_mem_responder.md
# dcache_mem_responder

Memory-side responder for the data-cache line refill/writeback protocol. It accepts burst read requests from `dcache_line` and returns `BURSTLEN` words with a per-word valid strobe, and it absorbs writeback words into an internal word-addressed backing store. It sits between the cache lines and the external memory controller, and doubles as the memory model in cache benches.

## Interface
Parameters:
- `ADDRBITS`, 32, byte address width
- `DATABITS`, 32, word width
- `MEMBITS`, 12, log2 of backing-store depth in words
- `BURSTLEN`, 32, words per read burst (equals `CACHEWORDS`)
- `RDLAT`, 4, clocks from accepted `mem_rdreq` to first `mem_valid`; must be ≥1

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_addr`  in  ADDRBITS  byte address; bits [1:0] ignored
- `mem_rdreq`  in  1  one-cycle read-burst request; start address taken from `mem_addr`
- `mem_wrreq`  in  1  write strobe; one word per high cycle
- `mem_datain`  in  DATABITS  write data (cache `line_out`)
- `mem_stall`  in  1  back-pressure/gap injection for read bursts
- `mem_out`  out  DATABITS  read data, registered
- `mem_valid`  out  1  `mem_out` holds a burst word this cycle
- `mem_burstlen`  out  16  constant `BURSTLEN`
- `mem_busy`  out  1  read burst in progress
- `mem_rderr`  out  1  one-cycle pulse: `mem_rdreq` rejected while busy

## Operation
- Word index = `mem_addr[MEMBITS+1:2]`. Higher address bits are ignored, so the store aliases modulo depth.
- FSM states: IDLE, WAIT, BURST.
  - IDLE → WAIT on `mem_rdreq`. This latches the start index, clears the word counter, and loads the latency counter.
  - WAIT → BURST when the latency counter expires.
  - BURST → IDLE after word `BURSTLEN-1` is issued.
- Burst word k is read from `(start + k) mod 2^MEMBITS`. The index wraps at the top of the store.
- Write: every cycle with `mem_wrreq` high stores `mem_datain` at the current `mem_addr` word index. Writes are accepted in any state.
- Write/read collision (single port): if the write and the next burst word fall in the same cycle, the write wins. That burst word is deferred one cycle and `mem_valid` is low for that cycle.
- `mem_stall` high in BURST: no word is issued the next cycle, and the counter holds.
- `mem_rdreq` while not IDLE: the request is ignored, `mem_rderr` pulses the next cycle, and the current burst is unaffected.
- `mem_rdreq` and `mem_wrreq` in the same IDLE cycle: both are accepted. The write commits first, so a burst covering that address returns the new data.
- Reset: FSM → IDLE and counters cleared. The backing store is not cleared.

## Timing
- Reset values: `mem_out`=0, `mem_valid`=0, `mem_busy`=0, `mem_rderr`=0. `mem_burstlen` always equals `BURSTLEN`.
- `mem_rdreq` sampled at edge 0:
  - `mem_busy` is high from cycle 1.
  - Word 0 is valid in cycle `RDLAT` when there are no stalls or collisions.
  - Word k is valid in cycle `RDLAT+k` plus the number of stall/collision cycles before it.
- `mem_busy` falls in the cycle after the last valid word. A new `mem_rdreq` is accepted from that cycle on.
- Stall and collision each cost exactly one gap cycle per asserted cycle. Exactly `BURSTLEN` valid cycles occur per burst.
- Reset asserted mid-burst: `mem_valid` and `mem_busy` are low in the following cycle, and no further words are issued.

## Structure
- A shared package holds the width defines (`ADDRBITS`, `DATABITS`, `CACHEWORDS`, `CACHEADDRBITS`) and the FSM state encoding, common with `dcache_line`.
- Sub-module `mem_sram`: a single-port synchronous RAM (one read or write per cycle, read data next cycle). The responder compensates for its one-cycle read latency inside WAIT/BURST so that the `RDLAT` timing holds.

## Test plan
- Write then read back: 32 `mem_wrreq` cycles at `0xd00faf80`+4k with data `0x100+k`, then `mem_rdreq` at `0xd00faf80` → first `mem_valid` exactly 4 clocks later, 32 consecutive words `0x100`..`0x11f`, then `mem_busy` low.
- Stall gap: `mem_stall` high for one cycle at word 3 → one `mem_valid` low cycle, word 3 (`0x103`) follows, and the burst is still exactly 32 words.
- Second request while busy: a `mem_rdreq` at `0xcccccccc` during the burst → `mem_rderr` pulses once and the original burst data is unchanged.
- Wrap-around: read at word index `2^MEMBITS-2` → words from indices 4094, 4095, 0, 1, ... in order.
- Collision: `mem_wrreq` of `0xdeadbeef` to word 10 of the active burst, issued while word 5 is due → `mem_valid` gap of one cycle, and word 10 returns `0xdeadbeef`.
- Reset at word 7 → `mem_valid` and `mem_busy` are 0 the next cycle, and a re-read after reset returns the previously written data.
